// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock-divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 26;

  typedef logic [CNT_W_DEFAULT-1:0] half_t;

  localparam half_t HALF_OFF = '0;

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle of the clock-divider bank: channel programming in, divided clocks out.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = clk_div_pkg::CNT_W_DEFAULT
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending;

  modport master (
    output div_we, div_sel, div_val, en, sync,
    input  clk_out, rise, pending
  );

  modport slave (
    input  div_we, div_sel, div_val, en, sync,
    output clk_out, rise, pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter with a shadow register applied only at period boundaries.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W        = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(2)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] div_val,
  input  logic             en,
  input  logic             sync,
  output logic             clk_out,
  output logic             rise,
  output logic             pending
);

  localparam logic [CNT_W-1:0] OFF = CNT_W'(HALF_OFF);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] half_r_reg, half_r_next;
  logic [CNT_W-1:0] half_p_reg, half_p_next;
  logic             pend_reg, pend_next;
  logic             out_reg, out_next;
  logic             rise_reg, rise_next;

  always_comb begin
    cnt_next    = cnt_reg;
    half_r_next = half_r_reg;
    half_p_next = half_p_reg;
    pend_next   = pend_reg;
    out_next    = out_reg;
    rise_next   = 1'b0;
    if (sync) begin
      // A write landing with sync bypasses the shadow and is applied at once.
      cnt_next = '0;
      out_next = 1'b0;
      if (wr) begin
        half_r_next = div_val;
        half_p_next = div_val;
        pend_next   = 1'b0;
      end else if (pend_reg) begin
        half_r_next = half_p_reg;
        pend_next   = 1'b0;
      end
    end else begin
      if (half_r_reg == OFF) begin
        cnt_next = '0;
        out_next = 1'b0;
        if (pend_reg) begin
          half_r_next = half_p_reg;
          pend_next   = 1'b0;
        end
      end else if (en) begin
        if (cnt_reg == half_r_reg - CNT_W'(1)) begin
          cnt_next  = '0;
          out_next  = ~out_reg;
          rise_next = ~out_reg;
          // Only the high->low toggle closes a full period, so swap there.
          if (out_reg && pend_reg) begin
            half_r_next = half_p_reg;
            pend_next   = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      // A write in the same cycle as an apply re-arms the shadow with the new value.
      if (wr) begin
        half_p_next = div_val;
        pend_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      half_r_reg <= DEFAULT_HALF;
      half_p_reg <= '0;
      pend_reg   <= 1'b0;
      out_reg    <= 1'b0;
      rise_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      half_r_reg <= half_r_next;
      half_p_reg <= half_p_next;
      pend_reg   <= pend_next;
      out_reg    <= out_next;
      rise_reg   <= rise_next;
    end
  end

  assign clk_out = out_reg;
  assign rise    = rise_reg;
  assign pending = pend_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock dividers with per-channel write decode.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH       = 4,
  parameter int               CNT_W        = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(2)
) (
  input  logic          clk_in,
  input  logic          rst,
  clk_div_bank_if.slave bus
);

  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] pending_w;

  // Full-width compare: select codes beyond the last channel match nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr[gi] = bus.div_we && (int'(bus.div_sel) == gi);

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .wr      (wr[gi]),
      .div_val (bus.div_val),
      .en      (bus.en[gi]),
      .sync    (bus.sync),
      .clk_out (clk_out_w[gi]),
      .rise    (rise_w[gi]),
      .pending (pending_w[gi])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.rise    = rise_w;
  assign bus.pending = pending_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed plus random stimulus against a period-position reference model of the divider bank.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH = 4;
  localparam int W   = CNT_W_DEFAULT;
  localparam int DEF = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  always #5 clk_in = ~clk_in;

  clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(W)) bus ();
  clk_div_bank_if #(.NUM_CH(3),   .CNT_W(W)) bus3 ();

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(W), .DEFAULT_HALF(W'(DEF))) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  // Three-channel bank: select code 3 is out of range and must be ignored.
  clk_div_bank #(.NUM_CH(3), .CNT_W(W), .DEFAULT_HALF(W'(DEF))) dut3 (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus3)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Model: position within the current output period (0..2H-1); output is high in the second half.
  int unsigned act  [NCH];
  int unsigned shd  [NCH];
  int unsigned tick [NCH];
  bit          has  [NCH];
  bit          rse  [NCH];
  int unsigned k3;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      act[i] = DEF; shd[i] = 0; tick[i] = 0; has[i] = 0; rse[i] = 0;
    end
    k3 = 0;
  endfunction

  function automatic void model_edge();
    bit wr;
    int unsigned v;
    for (int i = 0; i < NCH; i++) begin
      wr = bus.div_we && (int'(bus.div_sel) == i);
      v  = int'(bus.div_val);
      rse[i] = 0;
      if (bus.sync) begin
        tick[i] = 0;
        if (wr) begin act[i] = v; has[i] = 0; end
        else if (has[i]) begin act[i] = shd[i]; has[i] = 0; end
      end else begin
        if (act[i] == 0) begin
          tick[i] = 0;
          if (has[i]) begin act[i] = shd[i]; has[i] = 0; end
        end else if (bus.en[i]) begin
          tick[i]++;
          if (tick[i] == act[i]) rse[i] = 1;
          else if (tick[i] == 2 * act[i]) begin
            tick[i] = 0;
            if (has[i]) begin act[i] = shd[i]; has[i] = 0; end
          end
        end
        if (wr) begin shd[i] = v; has[i] = 1; end
      end
    end
    k3++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic check_all();
    logic [NCH-1:0] eo, er, ep;
    logic [2:0]     e3o, e3r;
    for (int i = 0; i < NCH; i++) begin
      eo[i] = (act[i] != 0) && (tick[i] >= act[i]);
      er[i] = rse[i];
      ep[i] = has[i];
    end
    e3o = ((k3 % 4) >= 2) ? 3'b111 : 3'b000;
    e3r = ((k3 % 4) == 2) ? 3'b111 : 3'b000;
    chk("clk_out", 32'(bus.clk_out), 32'(eo));
    chk("rise",    32'(bus.rise),    32'(er));
    chk("pending", 32'(bus.pending), 32'(ep));
    chk("bad_sel_clk_out", 32'(bus3.clk_out), 32'(e3o));
    chk("bad_sel_rise",    32'(bus3.rise),    32'(e3r));
    chk("bad_sel_pending", 32'(bus3.pending), 32'd0);
    $display("cyc=%0d we=%b sel=%0d val=%0d en=%b sync=%b | clk_out=%b rise=%b pending=%b",
             cyc, bus.div_we, bus.div_sel, bus.div_val, bus.en, bus.sync,
             bus.clk_out, bus.rise, bus.pending);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    cyc++;
    #1;
    check_all();
    bus3.div_val = W'($urandom_range(0, 9));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_ch(input int sel, input int val);
    bus.div_we  = 1'b1;
    bus.div_sel = 2'(sel);
    bus.div_val = W'(val);
    step();
    bus.div_we  = 1'b0;
  endtask

  initial begin
    bus.div_we = 1'b0; bus.div_sel = '0; bus.div_val = '0; bus.en = '1; bus.sync = 1'b0;
    bus3.div_we = 1'b1; bus3.div_sel = 2'd3; bus3.div_val = '0; bus3.en = '1; bus3.sync = 1'b0;
    model_reset();

    // Reset held: everything low.
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
    chk("reset_rise",    32'(bus.rise),    32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    rst = 1'b0;

    // Default half-period 2: rise[0] on edges 2, 6, 10.
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("default_rise0", 32'(bus.rise[0]), 32'((e == 2) || (e == 6) || (e == 10)));
      chk("default_out0",  32'(bus.clk_out[0]), 32'((e % 4) >= 2));
    end

    // ch1 written to 5 during its high phase; applies at the next falling edge.
    wr_ch(1, 5);
    chk("pending1_after_write", 32'(bus.pending[1]), 32'd1);
    run(30);

    // ch2 switched off, then back on at 3.
    wr_ch(2, 0);
    run(12);
    wr_ch(2, 3);
    run(10);

    // ch0 and ch3 at half 3 with different phases, then realigned by sync.
    wr_ch(0, 3);
    run(3);
    wr_ch(3, 3);
    run(15);
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync_out_low", 32'(bus.clk_out), 32'd0);
    run(2);
    step();
    chk("sync_aligned_rise", 32'(bus.rise[0] & bus.rise[3]), 32'd1);
    run(5);

    // Write to ch3 in the sync cycle takes effect immediately.
    bus.sync = 1'b1; bus.div_we = 1'b1; bus.div_sel = 2'd3; bus.div_val = W'(7);
    step();
    bus.sync = 1'b0; bus.div_we = 1'b0;
    run(30);

    // ch1 paused for 5 cycles mid-count.
    run(3);
    bus.en[1] = 1'b0;
    run(5);
    bus.en[1] = 1'b1;
    run(20);

    // Asynchronous reset with a write pending.
    wr_ch(0, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("async_rst_rise",    32'(bus.rise),    32'd0);
    chk("async_rst_pending", 32'(bus.pending), 32'd0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    model_reset();
    run(12);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      bus.div_we  = ($urandom_range(0, 9) == 0);
      bus.div_sel = 2'($urandom_range(0, 3));
      bus.div_val = W'($urandom_range(0, 6));
      for (int i = 0; i < NCH; i++) bus.en[i] = ($urandom_range(0, 7) != 0);
      bus.sync    = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock divider. It generates NUM_CH independent divided clocks (clk_out) and matching single-cycle rising-edge strobes (rise) from clk_in. Each channel's half-period is loaded from a register write and takes effect only at a period boundary, so there are no runt pulses. The block sits beside the top-level clock input and drives slow display, blink and game-tick logic. Downstream logic uses rise as a clock enable, never clk_out as a clock.

## Interface
- NUM_CH, 4, number of independent channels
- CNT_W, 26, counter and half-period width (covers 25_000_000 for 1 Hz from 50 MHz)
- DEFAULT_HALF, 2, half-period loaded into every channel at reset
- clk_in  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- div_we  in  1  write strobe for a new half-period
- div_sel  in  $clog2(NUM_CH)  target channel; indices >= NUM_CH are ignored
- div_val  in  CNT_W  new half-period in clk_in cycles; 0 means channel off
- en  in  NUM_CH  per-channel run enable
- sync  in  1  single-cycle pulse that realigns all channels
- clk_out  out  NUM_CH  divided clocks, 50% duty
- rise  out  NUM_CH  one-cycle strobe in the cycle clk_out[i] goes 0->1
- pending  out  NUM_CH  a written half-period is waiting to be applied

## Operation
Per-channel registers:
- cnt: CNT_W bits.
- half_r: active half-period.
- half_p: shadow half-period.
- pend: shadow-valid flag.
- out: the clk_out bit.

Reset values: cnt=0, out=0, half_r=DEFAULT_HALF, half_p=0, pend=0, rise=0. Therefore all outputs are 0 during and right after reset.

Write path:
- div_we with a valid div_sel sets half_p<=div_val and pend<=1 for that channel.
- A second write before apply overwrites half_p. Last write wins.

Priority per channel, evaluated each clk_in edge:
1. sync:
   - cnt<=0 and out<=0.
   - If pend, half_r<=half_p and pend<=0.
   - If div_we targets this channel in the same cycle, half_r<=div_val directly and pend<=0.
   - rise<=0.
2. half_r==0:
   - out<=0 and cnt<=0.
   - If pend, half_r<=half_p and pend<=0 on this edge.
3. !en[i]:
   - cnt and out hold.
   - rise<=0.
   - pend is still set by writes but not applied.
4. cnt==half_r-1:
   - cnt<=0 and out<=~out.
   - rise<=1 when out was 0.
   - When out was 1 (end of a full period) and pend, half_r<=half_p and pend<=0.
5. Otherwise: cnt<=cnt+1 and rise<=0.

Arithmetic and invariants:
- The compare is an unsigned CNT_W compare against half_r-1, evaluated only when half_r!=0.
- half_r changes only when cnt=0, so cnt<half_r always holds and the counter cannot run past the terminal count.
- Maximum half-period is 2^CNT_W-1.
- Output frequency is f_clk_in/(2*half_r).

## Timing
- After rst deasserts, the first clk_out 0->1 and first rise occur on the half_r-th clk_in edge. With DEFAULT_HALF=2 this is the 2nd edge.
- clk_out and rise are registered and change on the same edge. rise is high exactly 1 cycle per output period.
- A write is visible on pending the edge after div_we.
- A new half-period applies at the next falling transition of clk_out. It takes effect immediately if the channel is off or sync is asserted.
- After sync, the next rise comes half_r edges later, so all channels with equal half_r are phase-aligned.
- When en deasserts mid-count, clk_out freezes at its level. Counting resumes from the held cnt; no cycles are lost or added.
- Asserting rst mid-operation forces all registers to their reset values immediately (asynchronously) and discards any pending writes.

## Structure
- Package clk_div_pkg:
  - CNT_W default.
  - Typedef half_t (logic [CNT_W-1:0]).
  - Constant HALF_OFF=0.
- Sub-module clk_div_channel implements one channel: cnt, half_r, half_p, pend, out, rise.
  - Inputs: clk_in, rst, wr (decoded div_we && div_sel==i), div_val, en, sync.
- clk_div_bank decodes div_sel and instantiates NUM_CH channels in a generate loop.

## Test plan
- Reset, en=all 1, defaults: clk_out[0] rises on the 2nd edge after reset release, then period is 4 cycles, duty 2/2. rise[0] is high on edges 2, 6, 10.
- Write div_val=5 to ch1 mid-high-phase: pending[1]=1 the next edge. The current period completes at half=2. The next period is 10 cycles. pending[1] clears at the 1->0 transition.
- Write div_val=0 to ch2: after the current period ends, clk_out[2] stays 0 and rise[2] never pulses. Then write 3: the half-period loads on the next edge, and the first rise comes 3 edges later.
- Set ch0 half=3 and ch3 half=3 at different phases, then pulse sync: both outputs drop to 0 and rise together 3 edges after sync. A div_we to ch3 with value 7 in the sync cycle gives ch3 a period of 14.
- Deassert en[1] for 5 cycles mid-count: clk_out[1] holds its level. Total edges between rises increase by exactly 5.
- Assert rst asynchronously mid-period with a write pending: all clk_out, rise and pending go 0 immediately. After release, all channels run at DEFAULT_HALF.
- div_sel=NUM_CH with div_we=1: no pending bit set and no channel behaviour changes.
